// File: rtl/ps2_scancode_rx_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Scancode bundle between the PS/2 receiver and the downstream decoder.
interface ps2_scancode_rx_if;

    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       parity_err;
    logic       frame_err;

    modport master (
        output code, code_valid, is_break, is_extended, parity_err, frame_err
    );

    modport slave (
        input code, code_valid, is_break, is_extended, parity_err, frame_err
    );

endinterface

// File: rtl/ps2_scancode_rx_sync_edge.sv
// Synchronizes the raw PS/2 pins and flags ps2_clk falling edges.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic areset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data,
    output logic fe
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_hist;

    // Reset to 1 so a bus idling high produces no spurious edge after reset.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_hist  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value.
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_hist  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign data = data_sync[SYNC_STAGES-1];
    assign fe   = clk_hist & ~clk_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver with prefix folding and error detection.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    ps2_scancode_rx_if.master out
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic          data;
    logic          fe;
    logic          timeout;

    ps2_rx_state_t state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic [7:0]    code_q, code_d;
    logic          is_ext_q, is_ext_d;
    logic          is_brk_q, is_brk_d;
    logic          valid_q, valid_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic [CW-1:0] to_cnt_q;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .areset_n (areset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data     (data),
        .fe       (fe)
    );

    // A falling edge in the expiry cycle wins over the timeout.
    assign timeout = (state_q != IDLE) && !fe && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)                          to_cnt_q <= '0;
        else if (state_q == IDLE || fe || timeout) to_cnt_q <= '0;
        else                                    to_cnt_q <= to_cnt_q + 1'b1;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        code_d    = code_q;
        is_ext_d  = is_ext_q;
        is_brk_d  = is_brk_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (fe && !data) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fe) begin
                    shift_d = {data, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                    else                   bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: begin
                if (fe) begin
                    par_d   = data;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    state_d = IDLE;
                    if (!data) begin
                        ferr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                        ext_d  = 1'b0;
                        brk_d  = 1'b0;
                    end else if (shift_q == PS2_PREFIX_EXT) begin
                        ext_d = 1'b1;
                    end else if (shift_q == PS2_PREFIX_BREAK) begin
                        brk_d = 1'b1;
                    end else begin
                        code_d   = shift_q;
                        is_ext_d = ext_q;
                        is_brk_d = brk_q;
                        valid_d  = 1'b1;
                        ext_d    = 1'b0;
                        brk_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (timeout) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            code_q    <= '0;
            is_ext_q  <= 1'b0;
            is_brk_q  <= 1'b0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            code_q    <= code_d;
            is_ext_q  <= is_ext_d;
            is_brk_q  <= is_brk_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign out.code        = code_q;
    assign out.code_valid  = valid_q;
    assign out.is_break    = is_brk_q;
    assign out.is_extended = is_ext_q;
    assign out.parity_err  = perr_q;
    assign out.frame_err   = ferr_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: a small frame model queues expected strobes.
module tb_ps2_scancode_rx;

    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 500;
    localparam int HP             = 10;

    typedef enum logic [2:0] {
        EV_CODE = 3'b100,
        EV_PERR = 3'b010,
        EV_FERR = 3'b001
    } ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        int         exp_cyc;
    } ev_t;

    logic clk      = 1'b0;
    logic areset_n = 1'b0;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    int   cyc      = 0;
    int   total    = 0;
    int   bad      = 0;

    ev_t        sb[$];
    logic [7:0] m_code;
    logic       m_obrk, m_oext, m_pbrk, m_pext;

    ps2_scancode_rx_if sc_if ();

    ps2_scancode_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .out      (sc_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(input ev_kind_t k, input int exp_cyc);
        ev_t e;
        e.kind = k; e.code = m_code; e.brk = m_obrk; e.ext = m_oext; e.exp_cyc = exp_cyc;
        return e;
    endfunction

    // Reference behaviour of the receiver at the stop-bit edge.
    task automatic model_frame(input logic [7:0] b, input logic par, input logic stop, input int exp_cyc);
        if (!stop) begin
            m_pext = 0; m_pbrk = 0;
            sb.push_back(mk_ev(EV_FERR, exp_cyc));
        end else if ((^b ^ par) == 1'b0) begin
            m_pext = 0; m_pbrk = 0;
            sb.push_back(mk_ev(EV_PERR, exp_cyc));
        end else if (b == 8'hE0) begin
            m_pext = 1;
        end else if (b == 8'hF0) begin
            m_pbrk = 1;
        end else begin
            m_code = b; m_oext = m_pext; m_obrk = m_pbrk;
            m_pext = 0; m_pbrk = 0;
            sb.push_back(mk_ev(EV_CODE, exp_cyc));
        end
    endtask

    task automatic model_reset();
        m_code = 8'h00; m_obrk = 0; m_oext = 0; m_pbrk = 0; m_pext = 0;
    endtask

    task automatic ps2_bit(input logic b);
        repeat (HP / 2) @(posedge clk);
        #1 ps2_data = b;
        repeat (HP / 2) @(posedge clk);
        #1 ps2_clk = 1'b0;
        repeat (HP) @(posedge clk);
        #1 ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop);
        logic par;
        par = ~(^b) ^ flip_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        repeat (HP / 2) @(posedge clk);
        #1 ps2_data = stop;
        repeat (HP / 2) @(posedge clk);
        #1 ps2_clk = 1'b0;
        model_frame(b, par, stop, cyc + SYNC_STAGES + 1);
        repeat (HP) @(posedge clk);
        #1 ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3 * HP) @(posedge clk);
    endtask

    task automatic drained(input string tag);
        check(tag, sb.size(), 0);
    endtask

    // Compare every strobe the DUT raises against the head of the scoreboard.
    always @(negedge clk) begin
        logic [2:0] strobes;
        ev_t        e;
        strobes = {sc_if.code_valid, sc_if.parity_err, sc_if.frame_err};
        if (strobes != 3'b000) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", strobes, 3'b000);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", strobes, e.kind);
                check("code", sc_if.code, e.code);
                check("is_break", sc_if.is_break, e.brk);
                check("is_extended", sc_if.is_extended, e.ext);
                if (e.exp_cyc >= 0) check("latency", cyc, e.exp_cyc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_code", sc_if.code, 8'h00);
        check("rst_flags", {sc_if.code_valid, sc_if.is_break, sc_if.is_extended,
                            sc_if.parity_err, sc_if.frame_err}, 5'b0);
        areset_n = 1'b1;
        repeat (5) @(posedge clk);

        send_frame(8'h16, 0, 1'b1);
        drained("plain_16");

        send_frame(8'hF0, 0, 1'b1);
        send_frame(8'h45, 0, 1'b1);
        send_frame(8'h45, 0, 1'b1);
        drained("break_45");

        send_frame(8'hE0, 0, 1'b1);
        send_frame(8'hF0, 0, 1'b1);
        send_frame(8'hF0, 0, 1'b1);
        send_frame(8'h1E, 0, 1'b1);
        drained("ext_break_1e");

        send_frame(8'hF0, 0, 1'b1);
        send_frame(8'h26, 1, 1'b1);
        send_frame(8'h26, 0, 1'b1);
        drained("parity_26");

        send_frame(8'h3D, 1, 1'b0);
        drained("stop_3d");

        // Abandoned frame: start plus four bits, then the bus goes quiet.
        m_pext = 0; m_pbrk = 0;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        sb.push_back(mk_ev(EV_FERR, -1));
        repeat (TIMEOUT_CYCLES + 40) @(posedge clk);
        drained("timeout");
        send_frame(8'h3D, 0, 1'b1);
        drained("after_timeout_3d");

        // Reset in the middle of a frame.
        send_frame(8'hE0, 0, 1'b1);
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0]);
        @(posedge clk);
        #1 areset_n = 1'b0;
        #1;
        check("midrst_code", sc_if.code, 8'h00);
        check("midrst_flags", {sc_if.code_valid, sc_if.is_break, sc_if.is_extended,
                               sc_if.parity_err, sc_if.frame_err}, 5'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1 areset_n = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(8'h46, 0, 1'b1);
        drained("after_reset_46");

        // Single-cycle glitch on ps2_clk while idle with data high.
        @(posedge clk);
        #1 ps2_clk = 1'b0;
        @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (4 * HP) @(posedge clk);
        drained("glitch");
        send_frame(8'h1C, 0, 1'b1);
        drained("after_glitch_1c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
